reg_file_mp: RTL and testbench

Parametrised multi-port register file, the next generation of the CPU core's integer register file. Provides configurable width, depth, and read/write port counts, with optional hard-wired zero register and deterministic write-port priority. Adds a pending-write scoreboard for hazard detection, a sequential soft-clear engine and an optional write-to-read bypass. Sits between decode (read ports, scoreboard set) and writeback (write ports); the debug port feeds the simulation framework's register dump.

---
 rtl/reg_file_pkg.sv | 26 ++
 rtl/reg_file_sb.sv | 50 +++++
 rtl/reg_file_mp.sv | 171 +++++++++++++++++
 tb/tb_reg_file_mp.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// ============================================================================
// reg_file_pkg: shared defaults, clear-FSM states and port-slice helper.  Rev 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int DEPTH_DEF    = 32;
  localparam int NUM_RD_DEF   = 2;
  localparam int NUM_WR_DEF   = 1;
  localparam int ZERO_REG_DEF = 1;

  typedef enum logic [0:0] {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  // Low bit of port `port` inside a packed bus of `width`-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
// reg_file_sb: pending-write busy bits; set beats write-clear, clear engine wipes.  Rev 1.0
// ============================================================================
`default_nettype none

module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic                 wipe_en,
  input  logic [AW-1:0]        wipe_idx,
  output logic [DEPTH-1:0]     busy
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p]) busy_d[wr_addr[slice_lo(p, AW) +: AW]] = 1'b0;
    end
    if (set_en) busy_d[set_addr] = 1'b1;
    if (wipe_en) busy_d[wipe_idx] = 1'b0;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// reg_file_mp: multi-port register file with scoreboard and soft clear; define
// REG_FILE_BYPASS_EN for same-cycle write-to-read bypass.  Rev 1.0
// ============================================================================
`default_nettype none

module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     sb_set_en,
  input  logic [AW-1:0]            sb_set_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     wr_conflict,
  input  logic [AW-1:0]            dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  clr_state_e        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              conflict_q, conflict_d;

  logic [AW-1:0]     wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0] we;
  logic              idle;
  logic              set_en;
  logic [DEPTH-1:0]  busy;

  assign idle   = (state_q == CLR_IDLE);
  assign set_en = sb_set_en & idle;

  // Effective write enables: dropped while clearing and for the hard-wired zero entry.
  for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
    assign wa[p] = wr_addr[slice_lo(p, AW) +: AW];
    assign wd[p] = wr_data[slice_lo(p, DATA_W) +: DATA_W];
    assign we[p] = wr_en[p] & idle & ~((ZERO_REG != 0) && (wa[p] == '0));
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (we[a] && we[b] && (wa[a] == wa[b])) conflict_d = 1'b1;
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (we[p]) mem_d[wa[p]] = wd[p];
    end
    if (state_q == CLR_RUN) mem_d[idx_q] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
      idx_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      idx_q      <= idx_d;
      conflict_q <= conflict_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_RUN;
          idx_d   = '0;
        end
      end
      CLR_RUN: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) state_d = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state_q == CLR_RUN);
  end

  assign wr_conflict = conflict_q;

  reg_file_sb #(
    .DEPTH    (DEPTH),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (we),
    .wr_addr  (wr_addr),
    .set_en   (set_en),
    .set_addr (sb_set_addr),
    .wipe_en  (state_q == CLR_RUN),
    .wipe_idx (idx_q),
    .busy     (busy)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rdat;
    logic              rbusy;

    assign ra = rd_addr[slice_lo(i, AW) +: AW];

`ifdef REG_FILE_BYPASS_EN
    logic hit;
    // we[] already excludes entry 0 and the CLEAR state, so the bypass inherits both.
    always_comb begin
      rdat = mem_q[ra];
      hit  = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (we[p] && (wa[p] == ra)) begin
          rdat = wd[p];
          hit  = 1'b1;
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) rdat = '0;
      rbusy = busy[ra] & ~(hit & ~(set_en && (sb_set_addr == ra)));
    end
`else
    always_comb begin
      rdat  = ((ZERO_REG != 0) && (ra == '0)) ? '0 : mem_q[ra];
      rbusy = busy[ra];
    end
`endif

    assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = rdat;
    assign rd_busy[i] = rbusy;
  end

  assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : mem_q[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
// tb_reg_file_mp: scoreboard-driven self-checking bench for reg_file_mp (2 rd, 2 wr).  Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic        clr_req;
  logic        clr_busy;
  logic        wr_conflict;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] exp;

  always #5 clk = ~clk;

  reg_file_mp #(
    .DATA_W   (32),
    .DEPTH    (32),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .ZERO_REG (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .wr_conflict (wr_conflict),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [4:0] a, input logic [31:0] d);
    cycle();
    wr_en   = 2'b01;
    wr_addr = {5'd0, a};
    wr_data = {32'h0, d};
    if (a != 5'd0) ref_mem[a] = d;
    cycle();
    wr_en = 2'b00;
  endtask

  task automatic test_reset();
    rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    checks++;
    if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b expected 0", clr_busy); end
    checks++;
    if (wr_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b expected 0", wr_conflict); end
    checks++;
    if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", rd_busy); end
    checks++;
    if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    for (int e = 0; e < 32; e++) begin
      dbg_addr = 5'(e);
      #1;
      checks++;
      if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_entry%0d: got %h expected 0", e, dbg_data); end
    end
  endtask

  task automatic test_write();
    write1(5'd5, 32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h0);
    rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== exp) begin errors++; $display("FAIL write_r5: got %h expected %h", rd_data[31:0], exp); end
    exp = exp_q.pop_front();
    checks++;
    if (rd_data[63:32] !== exp) begin errors++; $display("FAIL read_r0: got %h expected %h", rd_data[63:32], exp); end
    write1(5'd0, 32'h12345678);
    exp_q.push_back(32'h0);
    dbg_addr = 5'd0;
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (dbg_data !== exp) begin errors++; $display("FAIL write_r0_dropped: got %h expected %h", dbg_data, exp); end
  endtask

  task automatic test_conflict();
    cycle();
    wr_en   = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h22222222, 32'h11111111};
    ref_mem[7] = 32'h22222222;
    exp_q.push_back(ref_mem[7]);
    cycle();
    wr_en   = 2'b00;
    rd_addr = {5'd0, 5'd7};
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== exp) begin errors++; $display("FAIL conflict_winner: got %h expected %h", rd_data[31:0], exp); end
    checks++;
    if (wr_conflict !== 1'b1) begin errors++; $display("FAIL conflict_pulse: got %b expected 1", wr_conflict); end
    cycle();
    @(negedge clk);
    checks++;
    if (wr_conflict !== 1'b0) begin errors++; $display("FAIL conflict_one_cycle: got %b expected 0", wr_conflict); end
    // Both ports on r0: dropped, not a conflict.
    cycle();
    wr_en   = 2'b11;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'hAAAA0000, 32'hBBBB0000};
    cycle();
    // Distinct addresses on both ports: both land, no conflict.
    wr_addr = {5'd2, 5'd1};
    wr_data = {32'h00000B0B, 32'h00000A0A};
    ref_mem[1] = 32'h00000A0A;
    ref_mem[2] = 32'h00000B0B;
    @(negedge clk);
    checks++;
    if (wr_conflict !== 1'b0) begin errors++; $display("FAIL conflict_r0_excluded: got %b expected 0", wr_conflict); end
    exp_q.push_back(ref_mem[1]);
    exp_q.push_back(ref_mem[2]);
    cycle();
    wr_en   = 2'b00;
    rd_addr = {5'd2, 5'd1};
    @(negedge clk);
    checks++;
    if (wr_conflict !== 1'b0) begin errors++; $display("FAIL conflict_distinct: got %b expected 0", wr_conflict); end
    exp = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== exp) begin errors++; $display("FAIL dual_write_p0: got %h expected %h", rd_data[31:0], exp); end
    exp = exp_q.pop_front();
    checks++;
    if (rd_data[63:32] !== exp) begin errors++; $display("FAIL dual_write_p1: got %h expected %h", rd_data[63:32], exp); end
  endtask

  task automatic test_scoreboard();
    cycle();
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd3;
    cycle();
    sb_set_en = 1'b0;
    rd_addr   = {5'd3, 5'd3};
    @(negedge clk);
    checks++;
    if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_set: got %b expected 1", rd_busy[0]); end
    // Clearing write in flight: bypass masks busy and forwards data.
    exp_q.push_back(BYP ? 32'h33333333 : ref_mem[3]);
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd3};
    wr_data = {32'h0, 32'h33333333};
    #1;
    checks++;
    if (rd_busy[0] !== !BYP) begin errors++; $display("FAIL sb_same_cycle_clear: got %b expected %b", rd_busy[0], !BYP); end
    exp = exp_q.pop_front();
    checks++;
    if (rd_data[31:0] !== exp) begin errors++; $display("FAIL sb_write_bypass: got %h expected %h", rd_data[31:0], exp); end
    ref_mem[3] = 32'h33333333;
    cycle();
    wr_en = 2'b00;
    @(negedge clk);
    checks++;
    if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_cleared: got %b expected 0", rd_busy[0]); end
    // Set and write together: set wins.
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd3;
    wr_en       = 2'b01;
    wr_data     = {32'h0, 32'h44444444};
    ref_mem[3]  = 32'h44444444;
    cycle();
    @(negedge clk);
    checks++;
    if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b expected 1", rd_busy[0]); end
    checks++;
    if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sb_set_wins_masked: got %b expected 1", rd_busy[1]); end
    cycle();
    sb_set_en = 1'b0;
    cycle();
    wr_en = 2'b00;
    @(negedge clk);
    checks++;
    if (rd_busy !== 2'b00) begin errors++; $display("FAIL sb_final_clear: got %b expected 00", rd_busy); end
  endtask

  task automatic test_bypass();
    write1(5'd9, 32'h00000055);
    rd_addr = {5'd9, 5'd0};
    @(negedge clk);
    exp_q.push_back(BYP ? 32'hCAFEF00D : 32'h00000055);
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd9};
    wr_data = {32'h0, 32'hCAFEF00D};
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (rd_data[63:32] !== exp) begin errors++; $display("FAIL bypass_r9: got %h expected %h", rd_data[63:32], exp); end
    ref_mem[9] = 32'hCAFEF00D;
    cycle();
    wr_en = 2'b00;
    exp_q.push_back(32'hCAFEF00D);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (rd_data[63:32] !== exp) begin errors++; $display("FAIL bypass_after: got %h expected %h", rd_data[63:32], exp); end
    exp_q.push_back(BYP ? 32'h0000000B : 32'hCAFEF00D);
    wr_en   = 2'b11;
    wr_addr = {5'd9, 5'd9};
    wr_data = {32'h0000000B, 32'h0000000A};
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (rd_data[63:32] !== exp) begin errors++; $display("FAIL bypass_priority: got %h expected %h", rd_data[63:32], exp); end
    ref_mem[9] = 32'h0000000B;
    cycle();
    rd_addr = {5'd0, 5'd0};
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
    #1;
    checks++;
    if (rd_data !== 64'h0) begin errors++; $display("FAIL bypass_r0: got %h expected 0", rd_data); end
    cycle();
    wr_en = 2'b00;
  endtask

  task automatic check_all_zero(input string tag);
    for (int e = 0; e < 32; e++) begin
      dbg_addr = 5'(e);
      rd_addr  = {5'(e), 5'(e)};
      #1;
      checks++;
      if (dbg_data !== 32'h0) begin errors++; $display("FAIL %s_entry%0d: got %h expected 0", tag, e, dbg_data); end
      checks++;
      if (rd_busy !== 2'b00) begin errors++; $display("FAIL %s_busy%0d: got %b expected 00", tag, e, rd_busy); end
      ref_mem[e] = 32'h0;
    end
  endtask

  task automatic fill_all();
    for (int e = 1; e < 32; e++) begin
      ref_mem[e] = 32'h01010101 * e + 32'h100;
      cycle();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'(e)};
      wr_data = {32'h0, ref_mem[e]};
    end
    cycle();
    wr_en       = 2'b00;
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd20;
    cycle();
    sb_set_en = 1'b0;
  endtask

  task automatic test_clear();
    int  cnt;
    bit  done;
    fill_all();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cnt  = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (clr_busy) cnt++;
      else if (cnt > 0) done = 1'b1;
      if (cnt == 16 && clr_busy) begin
        dbg_addr = 5'd20;
        exp_q.push_back(ref_mem[20]);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (dbg_data !== exp) begin errors++; $display("FAIL clear_partial: got %h expected %h", dbg_data, exp); end
      end
      if (cnt == 20) begin
        wr_en       = 2'b01;
        wr_addr     = {5'd0, 5'd5};
        wr_data     = {32'h0, 32'h00000BAD};
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd6;
        clr_req     = 1'b1;
      end
      if (cnt == 21) begin
        wr_en     = 2'b00;
        sb_set_en = 1'b0;
        clr_req   = 1'b0;
      end
    end
    checks++;
    if (cnt != 32) begin errors++; $display("FAIL clear_duration: got %0d expected 32", cnt); end
    checks++;
    if (clr_busy !== 1'b0) begin errors++; $display("FAIL clear_done: got %b expected 0", clr_busy); end
    check_all_zero("clear");
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    fill_all();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 11; c++) begin
      @(negedge clk);
      if (clr_busy) cnt++;
    end
    checks++;
    if (cnt != 11) begin errors++; $display("FAIL rst_mid_reach: got %0d expected 11", cnt); end
    rst_n    = 1'b0;
    dbg_addr = 5'd25;
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", clr_busy); end
    checks++;
    if (dbg_data !== 32'h0) begin errors++; $display("FAIL rst_mid_r25: got %h expected 0", dbg_data); end
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("rst_mid");
    cycle();
    @(negedge clk);
    checks++;
    if (clr_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b expected 0", clr_busy); end
  endtask

  initial begin
    rst_n       = 1'b0;
    rd_addr     = '0;
    wr_en       = '0;
    wr_addr     = '0;
    wr_data     = '0;
    sb_set_en   = 1'b0;
    sb_set_addr = '0;
    clr_req     = 1'b0;
    dbg_addr    = '0;
    for (int e = 0; e < 32; e++) ref_mem[e] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_write();
    test_conflict();
    test_scoreboard();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
